// File: rtl/cirno_pkg.sv
// Shared types and constants for the cirno core run controller.
// Holds the run FSM state type and the program-rotation helper.
package cirno_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } run_state_t;

    localparam int MAX_PROG = 4;
    localparam int PROG_IDW = 2;

    // Next program index in the rotation, wrapping after nprog-1.
    function automatic logic [PROG_IDW-1:0] next_prog(
        input logic [PROG_IDW-1:0] id,
        input int                  nprog
    );
        return (int'(id) == nprog - 1) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/run_wdog.sv
// Saturating up-counter with clear, enable and terminal-count flag.
// LIMIT=0 disables the terminal count; used for watchdog and cycle count.
module run_wdog #(
    parameter int W     = 16,
    parameter int LIMIT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] TC_VAL = W'(LIMIT - 1);

    // Count enabled cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (LIMIT != 0) && (cnt == TC_VAL);

endmodule

// File: rtl/run_ctrl.sv
// Run controller: init edge -> launch program, watch halt/watchdog -> done.
// Optional RUN_CTRL_CYCLE_COUNT_EN adds a 32-bit RUN cycle counter output.
module run_ctrl
    import cirno_pkg::*;
#(
    parameter int IW     = 10,
    parameter int NPROG  = 3,
    parameter int START0 = 0,
    parameter int START1 = 256,
    parameter int START2 = 512,
    parameter int START3 = 768,
    parameter int TMO    = 65535,
    parameter int TW     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic                halt,
    output logic                pc_load,
    output logic [IW-1:0]       pc_start,
    output logic                core_en,
    output logic                done,
    output logic                busy,
    output logic [PROG_IDW-1:0] prog_id,
    output logic                timeout
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    ,
    output logic [31:0]         cycles
`endif
);

    run_state_t          state;
    logic                init_q;
    logic                launch_ev;
    logic                go_launch;
    logic                run_en;
    logic                wd_tc;
    logic [TW-1:0]       wd_unused_cnt;
    logic [PROG_IDW-1:0] id_nxt;

    function automatic logic [IW-1:0] start_of(
        input logic [PROG_IDW-1:0] id
    );
        case (id)
            2'd0:    return IW'(START0);
            2'd1:    return IW'(START1);
            2'd2:    return IW'(START2);
            default: return IW'(START3);
        endcase
    endfunction

    assign launch_ev = init & ~init_q;
    assign run_en    = (state == RUN);

    // Decide whether a launch is accepted and which program it starts.
    always_comb begin
        go_launch = 1'b0;
        id_nxt    = prog_id;
        if (launch_ev && (state == IDLE)) begin
            go_launch = 1'b1;
        end else if (launch_ev && (state == DONE)) begin
            go_launch = 1'b1;
            id_nxt    = next_prog(prog_id, NPROG);
        end
    end

    // Run FSM plus launch bookkeeping (program index, start PC, timeout).
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            init_q   <= 1'b0;
            prog_id  <= '0;
            pc_start <= '0;
            timeout  <= 1'b0;
        end else begin
            init_q <= init;
            case (state)
                IDLE:    if (launch_ev) state <= LAUNCH;
                LAUNCH:  state <= RUN;
                RUN:     if (halt || wd_tc) state <= DONE;
                DONE:    if (launch_ev) state <= LAUNCH;
                default: state <= IDLE;
            endcase
            if (go_launch) begin
                prog_id  <= id_nxt;
                pc_start <= start_of(id_nxt);
                timeout  <= 1'b0;
            end
            if (run_en && !halt && wd_tc) begin
                timeout <= 1'b1;
            end
        end
    end

    // Outputs decode directly from the registered state.
    always_comb begin
        pc_load = (state == LAUNCH);
        core_en = (state == RUN);
        done    = (state == DONE);
        busy    = (state == LAUNCH) || (state == RUN);
    end

    run_wdog #(
        .W     (TW),
        .LIMIT (TMO)
    ) u_wdog (
        .clk   (clk),
        .reset (reset),
        .clr   (go_launch),
        .en    (run_en),
        .cnt   (wd_unused_cnt),
        .tc    (wd_tc)
    );

`ifdef RUN_CTRL_CYCLE_COUNT_EN
    logic cyc_unused_tc;

    run_wdog #(
        .W     (32),
        .LIMIT (0)
    ) u_cyc (
        .clk   (clk),
        .reset (reset),
        .clr   (go_launch),
        .en    (run_en),
        .cnt   (cycles),
        .tc    (cyc_unused_tc)
    );
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: launches and completions are queued as
// expectations and checked by a monitor when pc_load / done appear.
module tb_run_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic       halt;
    logic       pc_load;
    logic [9:0] pc_start;
    logic       core_en;
    logic       done;
    logic       busy;
    logic [1:0] prog_id;
    logic       timeout;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    logic [31:0] cycles;
`endif

    always #5 clk = ~clk;

    run_ctrl #(
        .TMO (50)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .halt     (halt),
        .pc_load  (pc_load),
        .pc_start (pc_start),
        .core_en  (core_en),
        .done     (done),
        .busy     (busy),
        .prog_id  (prog_id),
        .timeout  (timeout)
`ifdef RUN_CTRL_CYCLE_COUNT_EN
        ,
        .cycles   (cycles)
`endif
    );

    typedef struct {
        logic [9:0] pc;
        logic [1:0] id;
    } lexp_t;

    typedef struct {
        logic       tmo;
        logic [1:0] id;
        int         len;
    } dexp_t;

    lexp_t lq[$];
    dexp_t dq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cur_cyc = 0;
    int run_len = 0;
    logic done_q = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a launch or completion.
    always @(negedge clk) begin
        lexp_t le;
        dexp_t de;
        if (pc_load) begin
            if (lq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pc_load: got pc_start %0d expected none", pc_start);
            end else begin
                le = lq.pop_front();
                chk("launch_pc_start", pc_start, le.pc);
                chk("launch_prog_id", prog_id, le.id);
                chk("launch_core_en", core_en, 0);
                chk("launch_done", done, 0);
                chk("launch_busy", busy, 1);
                chk("launch_timeout", timeout, 0);
            end
            run_len = 0;
        end
        if (core_en) run_len++;
        if (done && !done_q) begin
            if (dq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got prog_id %0d expected none", prog_id);
            end else begin
                de = dq.pop_front();
                chk("done_timeout", timeout, de.tmo);
                chk("done_prog_id", prog_id, de.id);
                chk("done_run_len", run_len, de.len);
                chk("done_busy", busy, 0);
            end
        end
        done_q = done;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cur_cyc++;
    endtask

    // Launch with init held for 'hold' cycles; leaves us inside RUN.
    task automatic launch(input logic [9:0] pc, input logic [1:0] id, input int hold);
        lexp_t e;
        e.pc = pc;
        e.id = id;
        lq.push_back(e);
        init = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        init = 1'b0;
        if (hold == 1) begin
            @(posedge clk);
            #1;
            cur_cyc = 1;
        end else begin
            cur_cyc = hold - 1;
        end
        chk("core_en_latency", core_en, 1);
    endtask

    // Assert halt so it is sampled at the end of RUN cycle k.
    task automatic halt_at(input int k, input logic [1:0] id);
        dexp_t e;
        e.tmo = 1'b0;
        e.id  = id;
        e.len = k;
        dq.push_back(e);
        while (cur_cyc < k) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        step();
    endtask

    task automatic wait_done(input int len, input logic [1:0] id);
        dexp_t e;
        int i;
        e.tmo = 1'b1;
        e.id  = id;
        e.len = len;
        dq.push_back(e);
        for (i = 0; i < 100; i++) begin
            if (done) break;
            step();
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL watchdog_done: got done 0 expected 1 after %0d cycles", i);
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1;
        init  = 1'b0;
        halt  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_core_en", core_en, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pc_load", pc_load, 0);
        chk("rst_prog_id", prog_id, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_pc_start", pc_start, 0);
        reset = 1'b0;
        step();

        // first run, then rotation 256, 512 and wrap back to 0
        launch(10'd0, 2'd0, 1);
        halt_at(20, 2'd0);
        chk("done_held", done, 1);
        launch(10'd256, 2'd1, 1);
        halt_at(5, 2'd1);
        step();
        chk("pc_start_hold", pc_start, 256);
        launch(10'd512, 2'd2, 1);
        halt_at(7, 2'd2);
        launch(10'd0, 2'd0, 1);
        halt_at(3, 2'd0);

        // watchdog expiry, then a normal halted run
        launch(10'd256, 2'd1, 1);
        wait_done(50, 2'd1);
        chk("timeout_held", timeout, 1);
        launch(10'd512, 2'd2, 1);
        halt_at(10, 2'd2);

        // halt on the watchdog's last cycle: halt wins
        launch(10'd0, 2'd0, 1);
        halt_at(50, 2'd0);

        // init held 5 cycles, then re-pulsed during RUN
        launch(10'd256, 2'd1, 5);
        step();
        init = 1'b1;
        step();
        init = 1'b0;
        chk("run_core_en", core_en, 1);
        halt_at(8, 2'd1);

        // reset in the middle of a run
        launch(10'd512, 2'd2, 1);
        step();
        step();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_core_en", core_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_prog_id", prog_id, 0);
        chk("midrst_done", done, 0);
        step();
        launch(10'd0, 2'd0, 1);
        halt_at(4, 2'd0);

`ifdef RUN_CTRL_CYCLE_COUNT_EN
        launch(10'd256, 2'd1, 1);
        halt_at(37, 2'd1);
        chk("cycles_done", cycles, 37);
        step();
        chk("cycles_frozen", cycles, 37);
        begin
            lexp_t e;
            e.pc = 10'd512;
            e.id = 2'd2;
            lq.push_back(e);
        end
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        chk("cycles_cleared", cycles, 0);
        @(posedge clk);
        #1;
        cur_cyc = 1;
        halt_at(2, 2'd2);
`endif

        step();
        chk("launch_queue_empty", lq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
